// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// unified_mem_arbiter: serialises IF and DM accesses onto one single-ported memory,
// holds per-port read data and freezes the pipeline until the current slot is served. Rev 1.0
module unified_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              pipe_stall,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   if_pending, dm_pending, advance;
  logic   issue_if, issue_dm, capture;

  assign if_pending = if_req & ~if_done;
  assign dm_pending = dm_req & ~dm_done;
  assign pipe_stall = if_pending | dm_pending;
  assign advance    = ~pipe_stall;
  assign mem_valid  = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // DM wins over IF: the MEM-stage instruction is the older one.
  always_comb begin
    state_nxt = state;
    issue_if  = 1'b0;
    issue_dm  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (dm_pending) begin
          state_nxt = DM_WAIT;
          issue_dm  = 1'b1;
        end else if (if_pending) begin
          state_nxt = IF_WAIT;
          issue_if  = 1'b1;
        end
      end
      IF_WAIT, DM_WAIT: begin
        if (mem_ready) begin
          state_nxt = IDLE;
          capture   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are latched once at issue so they stay stable while waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (issue_dm) begin
      mem_addr  <= dm_addr;
      mem_we    <= dm_we;
      mem_wdata <= dm_wdata;
    end else if (issue_if) begin
      mem_addr  <= if_addr;
      mem_we    <= 1'b0;
    end else if (capture) begin
      mem_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_done  <= 1'b0;
      if_rdata <= '0;
    end else if (capture && state == IF_WAIT) begin
      if_done  <= 1'b1;
      if_rdata <= mem_rdata;
    end else if (advance) begin
      if_done  <= 1'b0;
    end
  end

  // A store completes the slot but leaves the previous load data in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dm_done  <= 1'b0;
      dm_rdata <= '0;
    end else if (capture && state == DM_WAIT) begin
      dm_done  <= 1'b1;
      if (!mem_we) dm_rdata <= mem_rdata;
    end else if (advance) begin
      dm_done  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// tb_unified_mem_arbiter: table vectors, randomized slots against a reference model,
// and a mid-access reset sequence for unified_mem_arbiter. Rev 1.0
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_done, dm_done, pipe_stall;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_valid, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .pipe_stall(pipe_stall),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic        if_req;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] if_addr;
    logic [31:0] dm_addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_stall;
    logic [31:0] exp_if;
    logic [31:0] exp_dm;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] resp_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  acc_t        log_q [$];
  int          cur_lat  = 0;
  logic        auto_mem = 1'b1;
  logic        man_ready = 1'b0;
  logic [31:0] man_rdata = '0;

  function automatic logic [31:0] hashw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] resp_rd(input logic [31:0] a);
    if (resp_mem.exists(a)) return resp_mem[a];
    return hashw(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return hashw(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: mem_ready rises lat cycles after mem_valid (lat=0: same cycle).
  initial begin
    int cnt;
    acc_t e;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!auto_mem) begin
        mem_ready = man_ready;
        mem_rdata = man_rdata;
        cnt = 0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_valid) begin
        if (cnt == cur_lat) begin
          mem_ready = 1'b1;
          if (mem_we) resp_mem[mem_addr] = mem_wdata;
          else        mem_rdata = resp_rd(mem_addr);
          e.we = mem_we; e.addr = mem_addr; e.wdata = mem_wdata;
          log_q.push_back(e);
        end else begin
          cnt++;
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the advance edge.
  task automatic run_slot(input vec_t v);
    int   stall_cnt;
    int   bound;
    int   we_bad;
    acc_t exp_q [$];
    acc_t e;
    stall_cnt = 0; bound = 0; we_bad = 0;
    log_q.delete();
    cur_lat  = v.lat;
    if_req   = v.if_req;  if_addr = v.if_addr;
    dm_req   = v.dm_req;  dm_we   = v.dm_we;
    dm_addr  = v.dm_addr; dm_wdata = v.wdata;
    @(negedge clk);
    while (pipe_stall && bound < 200) begin
      stall_cnt++;
      if (mem_we && !mem_valid) we_bad++;
      @(negedge clk);
      bound++;
    end
    check("stall_timeout", (bound < 200), 1);
    check("stall_cycles", stall_cnt, v.exp_stall);
    check("if_done", if_done, v.if_req);
    check("dm_done", dm_done, v.dm_req);
    check("if_rdata", if_rdata, v.exp_if);
    check("dm_rdata", dm_rdata, v.exp_dm);
    check("mem_we_idle", we_bad, 0);
    if (v.dm_req) begin
      e.we = v.dm_we; e.addr = v.dm_addr; e.wdata = v.wdata;
      exp_q.push_back(e);
    end
    if (v.if_req) begin
      e.we = 1'b0; e.addr = v.if_addr; e.wdata = '0;
      exp_q.push_back(e);
    end
    check("acc_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check("acc_addr", log_q[i].addr, exp_q[i].addr);
      check("acc_we", log_q[i].we, exp_q[i].we);
      if (exp_q[i].we) check("acc_wdata", log_q[i].wdata, exp_q[i].wdata);
    end
    @(posedge clk);
    #1;
    check("if_done_clr", if_done, 0);
    check("dm_done_clr", dm_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [7];
    vec_t        rv;
    logic [31:0] m_if, m_dm;
    int          n;

    reset = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    resp_mem[32'h40]  = 32'h2009_0005;
    resp_mem[32'h44]  = 32'h8C02_0004;
    resp_mem[32'h100] = 32'hDEAD_BEEF;

    //        if dm we if_addr       dm_addr       wdata         lat stall exp_if         exp_dm
    tbl[0] = '{1, 0, 0, 32'h40,      32'h0,        32'h0,        1,  3,    32'h2009_0005, 32'h0};
    tbl[1] = '{1, 1, 0, 32'h44,      32'h100,      32'h0,        0,  4,    32'h8C02_0004, 32'hDEAD_BEEF};
    tbl[2] = '{1, 1, 1, 32'h40,      32'h200,      32'hAA,       0,  4,    32'h2009_0005, 32'hDEAD_BEEF};
    tbl[3] = '{1, 0, 0, 32'h200,     32'h0,        32'h0,        0,  2,    32'hAA,        32'hDEAD_BEEF};
    tbl[4] = '{0, 1, 0, 32'h0,       32'h200,      32'h0,        2,  4,    32'hAA,        32'hAA};
    tbl[5] = '{0, 0, 0, 32'h0,       32'h0,        32'h0,        0,  0,    32'hAA,        32'hAA};
    tbl[6] = '{1, 0, 0, 32'h44,      32'h0,        32'h0,        3,  5,    32'h8C02_0004, 32'hAA};

    repeat (3) @(negedge clk);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_done", if_done, 0);
    check("rst_dm_done", dm_done, 0);
    check("rst_rdata", if_rdata | dm_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_slot(tbl[i]);

    // Randomized slots against the reference model; addresses share a small pool.
    m_if = tbl[6].exp_if;
    m_dm = tbl[6].exp_dm;
    for (int s = 0; s < 40; s++) begin
      rv.if_req  = 1'($urandom_range(0, 1));
      rv.dm_req  = 1'($urandom_range(0, 1));
      rv.dm_we   = 1'($urandom_range(0, 1));
      rv.if_addr = 32'h400 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      rv.dm_addr = 32'h400 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      rv.wdata   = $urandom;
      rv.lat     = int'($urandom_range(0, 3));
      n = 0;
      if (rv.dm_req) begin
        n++;
        if (rv.dm_we) ref_mem[rv.dm_addr] = rv.wdata;
        else          m_dm = ref_rd(rv.dm_addr);
      end
      if (rv.if_req) begin
        n++;
        m_if = ref_rd(rv.if_addr);
      end
      rv.exp_stall = n * (rv.lat + 2);
      rv.exp_if    = m_if;
      rv.exp_dm    = m_dm;
      run_slot(rv);
    end

    // Reset pulsed in the middle of a DM load; the late response must be ignored.
    if_req = 0; dm_req = 0;
    @(negedge clk);
    auto_mem = 1'b0; man_ready = 1'b0; man_rdata = '0;
    @(posedge clk); #1;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    @(posedge clk); #1;
    check("rstmid_valid_before", mem_valid, 1);
    #2;
    reset = 1'b0;
    dm_req = 0;
    #1;
    check("rstmid_valid", mem_valid, 0);
    check("rstmid_we", mem_we, 0);
    check("rstmid_addr", mem_addr, 0);
    check("rstmid_wdata", mem_wdata, 0);
    check("rstmid_if_rdata", if_rdata, 0);
    check("rstmid_dm_rdata", dm_rdata, 0);
    check("rstmid_done", {30'h0, if_done, dm_done}, 0);
    check("rstmid_stall", pipe_stall, 0);
    @(negedge clk);
    reset = 1'b1;
    man_ready = 1'b1; man_rdata = 32'h1234_5678;
    @(negedge clk);
    man_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("late_ready_done", dm_done, 0);
    check("late_ready_rdata", dm_rdata, 0);
    check("late_ready_valid", mem_valid, 0);
    auto_mem = 1'b1;
    @(posedge clk); #1;
    rv = '{1, 0, 0, 32'h40, 32'h0, 32'h0, 0, 2, 32'h2009_0005, 32'h0};
    run_slot(rv);
    if_req = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
